// File: rtl/mat_feeder.sv
// mat_feeder: holds 4x4 A and B operand matrices and streams the 16-step
// row-of-A / column-of-B schedule to a multiplier.
// Ports:
//   clk_80, rst_80 (sync, active-high)
//   wr_en_80 / wr_sel_80 / wr_addr_80 / wr_data_80 : operand writes (IDLE only)
//   start_80 : request one schedule
//   A00_80..A03_80, B00_80..B03_80 : registered operand outputs
//   valid_80, row_80, col_80, busy_80, done_80 : schedule status
module mat_feeder #(
  parameter int A_W = 9,
  parameter int B_W = 8
) (
  input  logic           clk_80,
  input  logic           rst_80,
  input  logic           wr_en_80,
  input  logic           wr_sel_80,
  input  logic [3:0]     wr_addr_80,
  input  logic [A_W-1:0] wr_data_80,
  input  logic           start_80,
  output logic [A_W-1:0] A00_80,
  output logic [A_W-1:0] A01_80,
  output logic [A_W-1:0] A02_80,
  output logic [A_W-1:0] A03_80,
  output logic [B_W-1:0] B00_80,
  output logic [B_W-1:0] B01_80,
  output logic [B_W-1:0] B02_80,
  output logic [B_W-1:0] B03_80,
  output logic           valid_80,
  output logic [1:0]     row_80,
  output logic [1:0]     col_80,
  output logic           busy_80,
  output logic           done_80
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state, state_n;

  // k is the step currently presented on the outputs
  logic [3:0] k, k_n;
  logic       load;
  logic       fin;
  logic       wr_ok;

  logic [A_W-1:0] a_mem [16];
  logic [B_W-1:0] b_mem [16];

  logic [A_W-1:0] a_q [4];
  logic [B_W-1:0] b_q [4];
  logic [A_W-1:0] a_n [4];
  logic [B_W-1:0] b_n [4];
  logic [1:0]     row_q, col_q;
  logic           valid_q, done_q;

  always_comb begin
    state_n = state;
    k_n     = k;
    load    = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_80) begin
          state_n = STREAM;
          k_n     = 4'd0;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (k == 4'd15) begin
          state_n = IDLE;
          k_n     = 4'd0;
          fin     = 1'b1;
        end else begin
          k_n  = k + 4'd1;
          load = 1'b1;
        end
      end
    endcase
  end

  // a start in the same cycle wins over a write
  assign wr_ok = (state == IDLE) && wr_en_80 && !start_80;

  // operands for the step about to be presented; zero when nothing is
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      a_n[n] = '0;
      b_n[n] = '0;
      if (load) begin
        a_n[n] = a_mem[{k_n[3:2], 2'(n)}];
        b_n[n] = b_mem[{2'(n), k_n[1:0]}];
      end
    end
  end

  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      state   <= IDLE;
      k       <= 4'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      for (int n = 0; n < 4; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
      end
      for (int e = 0; e < 16; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
      end
    end else begin
      state   <= state_n;
      k       <= k_n;
      valid_q <= load;
      done_q  <= fin;
      row_q   <= load ? k_n[3:2] : 2'd0;
      col_q   <= load ? k_n[1:0] : 2'd0;
      for (int n = 0; n < 4; n++) begin
        a_q[n] <= a_n[n];
        b_q[n] <= b_n[n];
      end
      if (wr_ok) begin
        if (wr_sel_80)
          b_mem[wr_addr_80] <= wr_data_80[B_W-1:0];
        else
          a_mem[wr_addr_80] <= wr_data_80;
      end
    end
  end

  assign A00_80   = a_q[0];
  assign A01_80   = a_q[1];
  assign A02_80   = a_q[2];
  assign A03_80   = a_q[3];
  assign B00_80   = b_q[0];
  assign B01_80   = b_q[1];
  assign B02_80   = b_q[2];
  assign B03_80   = b_q[3];
  assign valid_80 = valid_q;
  assign row_80   = row_q;
  assign col_80   = col_q;
  assign busy_80  = (state == STREAM);
  assign done_80  = done_q;

endmodule
